// File: rtl/scpad_sram_write_stage.sv
// -----------------------------------------------------------------------------
// scpad_sram_write_stage
//
// Final stage between the scratchpad SRAM write latch and the banks. Buffers
// assembled row-write requests in a small FIFO. Each request is rotated across
// the banks by its shift amount, and every element gets its own row offset.
// The result is presented as one registered per-bank command bundle.
// Requests with an all-zero valid mask are discarded and counted.
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   req_valid       latch has a request (held by the latch while be_stall=1)
//   req_wdata       row data, element i = bits [i*ELEM_W +: ELEM_W]
//   req_valid_mask  per-element write enable (pre-rotation)
//   req_shift       left rotation amount in elements
//   req_slot_mask   per-element row offset, ROW_W bits each (pre-rotation)
//   req_base_row    base row of the request
//   be_stall        backpressure to the latch (FIFO full)
//   bank_valid      per-bank command bundle valid
//   bank_ready      banks accept the bundle this cycle
//   bank_we         per-bank write enable
//   bank_row        per-bank row address, ROW_W bits each
//   bank_wdata      per-bank write data, ELEM_W bits each
//   drop_count      saturating count of all-zero-mask requests dropped
// -----------------------------------------------------------------------------
module scpad_sram_write_stage #(
    parameter int NUM_COLS = 32,
    parameter int ELEM_W   = 16,
    parameter int NUM_ROWS = 32,
    parameter int SHIFT_W  = $clog2(NUM_COLS),
    parameter int DEPTH    = 4,
    parameter int ROW_W    = $clog2(NUM_ROWS)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       req_valid,
    input  logic [NUM_COLS*ELEM_W-1:0] req_wdata,
    input  logic [NUM_COLS-1:0]        req_valid_mask,
    input  logic [SHIFT_W-1:0]         req_shift,
    input  logic [NUM_COLS*ROW_W-1:0]  req_slot_mask,
    input  logic [ROW_W-1:0]           req_base_row,
    output logic                       be_stall,
    output logic                       bank_valid,
    input  logic                       bank_ready,
    output logic [NUM_COLS-1:0]        bank_we,
    output logic [NUM_COLS*ROW_W-1:0]  bank_row,
    output logic [NUM_COLS*ELEM_W-1:0] bank_wdata,
    output logic [15:0]                drop_count
);

    localparam int DATA_W = NUM_COLS * ELEM_W;
    localparam int SLOT_W = NUM_COLS * ROW_W;
    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = PTR_W + 1;

    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    typedef struct packed {
        logic [DATA_W-1:0]   wdata;
        logic [NUM_COLS-1:0] valid_mask;
        logic [SHIFT_W-1:0]  shift;
        logic [SLOT_W-1:0]   slot_mask;
        logic [ROW_W-1:0]    base_row;
    } req_t;

    req_t              fifo_mem [DEPTH];
    req_t              in_req;
    req_t              head;
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;

    logic              push;
    logic              pop;
    logic              fifo_nonempty;
    logic              head_drop;
    logic              out_free;
    logic              load;

    logic [NUM_COLS-1:0] nxt_we;
    logic [SLOT_W-1:0]   nxt_row;
    logic [DATA_W-1:0]   nxt_wdata;
    logic [SHIFT_W-1:0]  src;

    assign in_req = '{
        wdata:      req_wdata,
        valid_mask: req_valid_mask,
        shift:      req_shift,
        slot_mask:  req_slot_mask,
        base_row:   req_base_row
    };

    // Stall depends on the registered count only, so the latch never sees a
    // combinational path from bank_ready.
    assign be_stall      = (count == CNT_FULL);
    assign push          = req_valid && !be_stall;
    assign fifo_nonempty = (count != '0);
    assign head          = fifo_mem[rd_ptr];

    // An empty-mask head is discarded without needing the output register, so
    // it never waits behind a stalled bundle.
    assign head_drop = fifo_nonempty && (head.valid_mask == '0);
    assign out_free  = !bank_valid || bank_ready;
    assign load      = fifo_nonempty && !head_drop && out_free;
    assign pop       = load || head_drop;

    // NOTE: the storage array has no reset; validity is tracked only by the
    // pointers and count, so clearing the data would buy nothing.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= in_req;
        end
    end

    // NOTE: every sequential block uses non-blocking assignments so all
    // registers update from the same pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
            case ({push, pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: ;
            endcase
        end
    end

    // Rotation is done from the bank's point of view. Bank b takes source
    // element (b - shift) mod NUM_COLS, which equals b = (i + shift) mod NUM_COLS.
    // NOTE: every output of this block gets a default first, so no path can
    // leave a stale value and infer a latch.
    always_comb begin
        nxt_we    = '0;
        nxt_row   = '0;
        nxt_wdata = '0;
        src       = '0;
        for (int b = 0; b < NUM_COLS; b++) begin
            src = SHIFT_W'(b) - head.shift;
            nxt_we[b] = head.valid_mask[src];
            nxt_row[b*ROW_W +: ROW_W] =
                head.base_row + head.slot_mask[int'(src)*ROW_W +: ROW_W];
            nxt_wdata[b*ELEM_W +: ELEM_W] = head.wdata[int'(src)*ELEM_W +: ELEM_W];
        end
    end

    // The output register only moves when the banks have taken the current
    // bundle or there is none. The payload holds when bank_valid falls.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bank_valid <= 1'b0;
            bank_we    <= '0;
            bank_row   <= '0;
            bank_wdata <= '0;
        end else if (out_free) begin
            bank_valid <= load;
            if (load) begin
                bank_we    <= nxt_we;
                bank_row   <= nxt_row;
                bank_wdata <= nxt_wdata;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drop_count <= '0;
        end else if (head_drop && (drop_count != 16'hFFFF)) begin
            drop_count <= drop_count + 16'd1;
        end
    end

endmodule

// File: tb/tb_scpad_sram_write_stage.sv
// -----------------------------------------------------------------------------
// tb_scpad_sram_write_stage
//
// Directed testbench for scpad_sram_write_stage. Inputs change and outputs are
// sampled 1 time unit after each rising clock edge.
// -----------------------------------------------------------------------------
module tb_scpad_sram_write_stage;

    logic         clk;
    logic         rst;
    logic         req_valid;
    logic [511:0] req_wdata;
    logic [31:0]  req_valid_mask;
    logic [4:0]   req_shift;
    logic [159:0] req_slot_mask;
    logic [4:0]   req_base_row;
    logic         be_stall;
    logic         bank_valid;
    logic         bank_ready;
    logic [31:0]  bank_we;
    logic [159:0] bank_row;
    logic [511:0] bank_wdata;
    logic [15:0]  drop_count;

    int errors = 0;
    int checks = 0;

    logic [511:0] exp_data;
    logic [511:0] stim_data;
    logic [159:0] exp_row;
    logic [159:0] stim_slot;

    scpad_sram_write_stage dut (
        .clk            (clk),
        .rst            (rst),
        .req_valid      (req_valid),
        .req_wdata      (req_wdata),
        .req_valid_mask (req_valid_mask),
        .req_shift      (req_shift),
        .req_slot_mask  (req_slot_mask),
        .req_base_row   (req_base_row),
        .be_stall       (be_stall),
        .bank_valid     (bank_valid),
        .bank_ready     (bank_ready),
        .bank_we        (bank_we),
        .bank_row       (bank_row),
        .bank_wdata     (bank_wdata),
        .drop_count     (drop_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_req(input logic [511:0] d, input logic [31:0] m, input logic [4:0] s,
                             input logic [159:0] sl, input logic [4:0] b);
        req_valid      = 1'b1;
        req_wdata      = d;
        req_valid_mask = m;
        req_shift      = s;
        req_slot_mask  = sl;
        req_base_row   = b;
    endtask

    // Row whose element i is i, except element 0, which carries a tag.
    function automatic logic [511:0] tag_row(input logic [15:0] tag);
        logic [511:0] r;
        r = '0;
        for (int i = 0; i < 32; i++) r[i*16 +: 16] = 16'(i);
        r[15:0] = tag;
        return r;
    endfunction

    initial begin
        rst            = 1'b1;
        req_valid      = 1'b0;
        req_wdata      = '0;
        req_valid_mask = '0;
        req_shift      = '0;
        req_slot_mask  = '0;
        req_base_row   = '0;
        bank_ready     = 1'b0;

        // Reset state
        tick();
        tick();
        check("rst_stall", be_stall, 0);
        check("rst_valid", bank_valid, 0);
        check("rst_we", bank_we, 0);
        check("rst_row", bank_row, 0);
        check("rst_wdata", bank_wdata, 0);
        check("rst_drop", drop_count, 0);
        rst = 1'b0;
        tick();
        check("idle_valid", bank_valid, 0);

        // 1. Single request, no rotation, base row 3
        bank_ready = 1'b1;
        drive_req(tag_row(16'd0), 32'hFFFF_FFFF, 5'd0, '0, 5'd3);
        tick();
        req_valid = 1'b0;
        check("t1_latency", bank_valid, 0);
        tick();
        check("t1_valid", bank_valid, 1);
        check("t1_we", bank_we, 32'hFFFF_FFFF);
        check("t1_row", bank_row, {32{5'd3}});
        check("t1_wdata", bank_wdata, tag_row(16'd0));
        tick();
        check("t1_fall", bank_valid, 0);

        // 2. Rotation by 5 and row wrap (4 + 30 = 34 -> 2)
        stim_data = '0;
        stim_data[15:0] = 16'hBEEF;
        stim_slot = '0;
        stim_slot[4:0] = 5'd30;
        exp_data = '0;
        exp_data[5*16 +: 16] = 16'hBEEF;
        for (int b = 0; b < 32; b++) exp_row[b*5 +: 5] = (b == 5) ? 5'd2 : 5'd4;
        drive_req(stim_data, 32'h0000_0001, 5'd5, stim_slot, 5'd4);
        tick();
        req_valid = 1'b0;
        tick();
        check("t2_valid", bank_valid, 1);
        check("t2_we", bank_we, 32'h0000_0020);
        check("t2_row", bank_row, exp_row);
        check("t2_wdata", bank_wdata, exp_data);
        tick();
        check("t2_fall", bank_valid, 0);

        // 3. Backpressure: 5 requests fill FIFO + output register, 6th held
        bank_ready = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            drive_req(tag_row(16'(k)), 32'hFFFF_FFFF, 5'd0, '0, 5'd0);
            tick();
        end
        drive_req(tag_row(16'd6), 32'hFFFF_FFFF, 5'd0, '0, 5'd0);
        check("t3_stall_full", be_stall, 1);
        check("t3_head_out", bank_wdata, tag_row(16'd1));
        tick();
        tick();
        check("t3_stall_hold", be_stall, 1);
        check("t3_out_hold", bank_wdata, tag_row(16'd1));
        bank_ready = 1'b1;
        for (int k = 2; k <= 6; k++) begin
            tick();
            check($sformatf("t3_drain_valid_%0d", k), bank_valid, 1);
            check($sformatf("t3_drain_data_%0d", k), bank_wdata, tag_row(16'(k)));
            if (k == 2) check("t3_stall_release", be_stall, 0);
            if (k == 3) req_valid = 1'b0;
        end
        tick();
        check("t3_empty", bank_valid, 0);

        // 4. Drop between two valid requests
        drive_req(tag_row(16'd7), 32'hFFFF_FFFF, 5'd0, '0, 5'd0);
        tick();
        drive_req(tag_row(16'd8), 32'h0000_0000, 5'd0, '0, 5'd0);
        tick();
        check("t4_first_valid", bank_valid, 1);
        check("t4_first_data", bank_wdata, tag_row(16'd7));
        drive_req(tag_row(16'd9), 32'hFFFF_FFFF, 5'd0, '0, 5'd0);
        tick();
        req_valid = 1'b0;
        check("t4_drop_gap", bank_valid, 0);
        check("t4_drop_count", drop_count, 1);
        tick();
        check("t4_second_valid", bank_valid, 1);
        check("t4_second_data", bank_wdata, tag_row(16'd9));
        tick();
        check("t4_end", bank_valid, 0);

        // 5. Outputs stable while bank_ready is low
        drive_req(tag_row(16'd10), 32'hFFFF_FFFF, 5'd0, '0, 5'd0);
        tick();
        req_valid = 1'b0;
        tick();
        check("t5_valid", bank_valid, 1);
        bank_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            check($sformatf("t5_hold_valid_%0d", c), bank_valid, 1);
            check($sformatf("t5_hold_data_%0d", c), bank_wdata, tag_row(16'd10));
            check($sformatf("t5_hold_we_%0d", c), bank_we, 32'hFFFF_FFFF);
            check($sformatf("t5_hold_row_%0d", c), bank_row, 0);
        end
        bank_ready = 1'b1;
        tick();
        check("t5_release", bank_valid, 0);

        // 6. Reset mid-stream: count=3 and bank_valid=1
        bank_ready = 1'b0;
        for (int k = 11; k <= 14; k++) begin
            drive_req(tag_row(16'(k)), 32'hFFFF_FFFF, 5'd0, '0, 5'd0);
            tick();
        end
        req_valid = 1'b0;
        check("t6_pre_valid", bank_valid, 1);
        check("t6_pre_data", bank_wdata, tag_row(16'd11));
        #2;
        rst = 1'b1;
        #1;
        check("t6_rst_valid", bank_valid, 0);
        check("t6_rst_we", bank_we, 0);
        check("t6_rst_row", bank_row, 0);
        check("t6_rst_wdata", bank_wdata, 0);
        check("t6_rst_stall", be_stall, 0);
        check("t6_rst_drop", drop_count, 0);
        tick();
        rst = 1'b0;
        bank_ready = 1'b1;
        drive_req(tag_row(16'd15), 32'hFFFF_FFFF, 5'd0, '0, 5'd0);
        tick();
        req_valid = 1'b0;
        check("t6_post_latency", bank_valid, 0);
        tick();
        check("t6_post_valid", bank_valid, 1);
        check("t6_post_data", bank_wdata, tag_row(16'd15));
        tick();
        check("t6_post_empty", bank_valid, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
